iq_buffer: RTL and testbench
============================

// Module: iq_buffer
// PURPOSE
// - Instruction queue between decode/ROB-allocate and the issue stage. Circular buffer of iq_entry_t (dec_inst + rob_slot).
// - Writes up to 4 entries per cycle from decode. Presents the oldest 4 entries, in order, on the ext_* interface.
// - Retires 1-4 entries per cycle, as issue reports through ext_enable/ext_consumed.
// - Flushed on branch mispredict/redirect.
// PARAMETERS
// DEPTH    16   entries; power of 2, >= 8
// PTR_W    $clog2(DEPTH)   pointer width (derived, do not override)
// PORTS
// clock          in   1        clock, posedge
// reset_n        in   1        async reset, active-low
// flush          in   1        sync clear of all entries
// in_enable      in   1        decode write strobe
// in_count       in   2        entries written minus 1 (0 -> 1 entry, 3 -> 4 entries)
// in_insns[4]    in   iq_entry_t  write data; lane 0 oldest; lanes > in_count ignored
// in_ready       out  1        space for 4 entries this cycle
// ext_enable     in   1        issue retires entries this cycle
// ext_consumed   in   2        entries retired minus 1
// ext_valid[4]   out  1 each   lane i holds a valid entry
// insns[4]       out  iq_entry_t  oldest-first entries
// empty          out  1        no valid entries
// occupancy      out  PTR_W+1  current entry count
// BEHAVIOUR
// - State: mem[DEPTH], rd_ptr, wr_ptr (PTR_W, wrap modulo DEPTH), count (PTR_W+1). No FSM beyond pointer/count regs.
// - Reset (async, reset_n=0): rd_ptr=wr_ptr=0, count=0. Outputs: empty=1, in_ready=1, occupancy=0, ext_valid all 0, insns all '0.
//   - mem contents are not reset.
// - Read side (combinational from registered state, zero latency):
//   - ext_valid[i] = (count > i).
//   - insns[i] = mem[(rd_ptr+i) mod DEPTH] when ext_valid[i], else '0.
//   - empty = (count==0).
// - pop = ext_enable ? ext_consumed+1 : 0.
//   - pop > count is a protocol violation: SVA assertion fires, pop is clamped to count.
//   - ext_enable must not be asserted while empty.
// - in_ready = (DEPTH - count) >= 4, registered-state based. It does not depend on the same-cycle pop, so there is no comb path ext_* -> in_ready.
// - push = (in_enable & in_ready) ? in_count+1 : 0.
//   - A write with in_ready=0 is dropped; assertion fires.
// - Posedge update (flush=0):
//   - mem[(wr_ptr+k) mod DEPTH] <= in_insns[k] for k < push.
//   - wr_ptr += push; rd_ptr += pop; count <= count + push - pop.
// - Latency: an entry written at edge N is visible on ext_* after edge N. There is no write->read bypass, including when empty.
// - Simultaneous push and pop are both honoured in the same cycle. Push slots never alias pop slots, because in_ready guarantees >= 4 free slots.
// - Wrap-around: writes and reads spanning index DEPTH-1 -> 0 are handled per lane via modulo indexing.
// - flush=1: rd_ptr=wr_ptr=0, count=0 at the next edge. Flush overrides same-cycle push and pop. Outputs match reset values the following cycle.
// - Reset asserted mid-operation: immediate async return to reset state. In-flight write is lost.
// - Full: count==DEPTH gives in_ready=0 and all ext_valid=1. count > DEPTH-4 also gives in_ready=0.
// TESTING
// 1. Reset, no stimulus -> empty=1, in_ready=1, occupancy=0, ext_valid=0000, insns=0.
// 2. Write 3 entries (in_count=2, rob_slot 1,2,3) -> next cycle ext_valid=1110, insns[0..2].rob_slot=1,2,3, occupancy=3.
// 3. occupancy=3, pop 2 (ext_consumed=1) with same-cycle write of 4 (slots 4-7) -> next cycle occupancy=5, insns rob_slot=3,4,5,6.
// 4. Fill to 13 -> in_ready=0, and an in_enable write is dropped (assert).
//    - Then pop 1 -> in_ready=1 next cycle.
//    - Then fill to 16 -> ext_valid=1111.
// 5. rd_ptr=wr_ptr=14, write 4 -> entries land in mem 14,15,0,1; insns in order; occupancy=4.
// 6. occupancy=8, flush with same-cycle push 4 and pop 4 -> next cycle occupancy=0, empty=1.
//    - Then write 1 -> occupancy=1, insns[0] = new entry.

Source files
------------

// File: rtl/iq_buffer.sv
// iq_buffer: instruction queue between decode/ROB-allocate and issue.
// Circular buffer of iq_entry_t. Decode writes up to 4 entries per cycle.
// The oldest 4 entries are shown in order on the ext_* side, and issue
// retires 1-4 of them per cycle.
//
// Ports:
//   clock, reset_n      posedge clock, async active-low reset
//   flush               sync clear of all entries (wins over push/pop)
//   in_enable/in_count  decode write strobe, entries written minus 1
//   in_insns[4]         write data, lane 0 oldest
//   in_ready            room for 4 entries (from registered count only)
//   ext_enable/ext_consumed  issue retires ext_consumed+1 entries
//   ext_valid[3:0]      lane i holds a valid entry
//   insns[4]            oldest-first entries, '0 on invalid lanes
//   empty, occupancy    entry count status

package iq_buffer_pkg;
   typedef struct packed {
      logic [31:0] dec_inst;
      logic [5:0]  rob_slot;
   } iq_entry_t;
endpackage

module iq_buffer
   import iq_buffer_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_enable,
   input  logic [1:0]       in_count,
   input  iq_entry_t        in_insns [4],
   output logic             in_ready,
   input  logic             ext_enable,
   input  logic [1:0]       ext_consumed,
   output logic [3:0]       ext_valid,
   output iq_entry_t        insns [4],
   output logic             empty,
   output logic [PTR_W:0]   occupancy
);

   localparam int CNT_W = PTR_W + 1;

   iq_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] pop_req;
   logic [CNT_W-1:0] pop;
   logic [CNT_W-1:0] push;

   // in_ready looks only at the registered count, so a same-cycle pop never
   // frees space for a write; this keeps ext_* off the in_ready path and
   // guarantees push slots never alias slots still being read.
   assign in_ready  = (CNT_W'(DEPTH) - count) >= CNT_W'(4);
   assign empty     = (count == '0);
   assign occupancy = count;

   always_comb begin
      pop_req = '0;
      if (ext_enable)
         pop_req = CNT_W'(ext_consumed) + CNT_W'(1);
      // An over-retire is clamped to what is actually held.
      pop = (pop_req > count) ? count : pop_req;
      push = '0;
      if (in_enable && in_ready)
         push = CNT_W'(in_count) + CNT_W'(1);
   end

   for (genvar i = 0; i < 4; i++) begin : g_read
      assign ext_valid[i] = (count > CNT_W'(i));
      assign insns[i]     = ext_valid[i] ? mem[rd_ptr + PTR_W'(i)] : '0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + push[PTR_W-1:0];
         rd_ptr <= rd_ptr + pop[PTR_W-1:0];
         count  <= count + push - pop;
      end
   end

   // Storage is not reset; pointer wrap gives the per-lane modulo indexing.
   always_ff @(posedge clock) begin
      if (reset_n && !flush) begin
         for (int k = 0; k < 4; k++) begin
            if (CNT_W'(k) < push)
               mem[wr_ptr + PTR_W'(k)] <= in_insns[k];
         end
      end
   end

   always @(posedge clock) begin
      if (reset_n && !flush) begin
         assert (!(ext_enable && (pop_req > count)))
            else $error("iq_buffer: retire of more entries than held");
         assert (!(in_enable && !in_ready))
            else $warning("iq_buffer: write dropped while in_ready low");
      end
   end

endmodule

// File: tb/tb_iq_buffer.sv
module tb_iq_buffer;
   import iq_buffer_pkg::*;

   localparam int DEPTH = 16;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_enable = 1'b0;
   logic [1:0]  in_count = '0;
   iq_entry_t   in_insns [4];
   logic        in_ready;
   logic        ext_enable = 1'b0;
   logic [1:0]  ext_consumed = '0;
   logic [3:0]  ext_valid;
   iq_entry_t   insns [4];
   logic        empty;
   logic [4:0]  occupancy;

   iq_buffer #(.DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_enable(in_enable), .in_count(in_count), .in_insns(in_insns),
      .in_ready(in_ready), .ext_enable(ext_enable), .ext_consumed(ext_consumed),
      .ext_valid(ext_valid), .insns(insns), .empty(empty), .occupancy(occupancy)
   );

   always #5 clock = ~clock;

   typedef struct {
      int        occ;
      logic [3:0] v;
      iq_entry_t e [4];
      bit        rdy;
      string     tag;
   } exp_t;

   iq_entry_t model [$];
   exp_t      exp_q [$];
   int        n_checks = 0;
   int        n_fail = 0;
   int        next_slot = 1;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   function automatic exp_t snapshot(string tag);
      exp_t x;
      x.tag = tag;
      x.occ = model.size();
      x.rdy = (model.size() <= DEPTH - 4);
      for (int i = 0; i < 4; i++) begin
         x.v[i] = (i < model.size());
         x.e[i] = (i < model.size()) ? model[i] : '0;
      end
      return x;
   endfunction

   // Monitor: after every edge where a stimulus cycle was issued, compare.
   always @(posedge clock) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t x;
         x = exp_q.pop_front();
         chk({x.tag, " occupancy"}, 64'(occupancy), 64'(x.occ));
         chk({x.tag, " ext_valid"}, 64'(ext_valid), 64'(x.v));
         chk({x.tag, " empty"}, 64'(empty), 64'(x.occ == 0));
         chk({x.tag, " in_ready"}, 64'(in_ready), 64'(x.rdy));
         for (int i = 0; i < 4; i++)
            chk($sformatf("%s insns[%0d]", x.tag, i), 64'(insns[i]), 64'(x.e[i]));
      end
   end

   // One stimulus cycle: drive at negedge, update the reference queue, queue
   // the expected post-edge view, then let the edge happen.
   task automatic step(input bit en, input int cnt, input bit xen,
                       input int xc, input bit fl, input string tag);
      bit ready;
      int n;
      @(negedge clock);
      ready = (model.size() <= DEPTH - 4);
      for (int k = 0; k < 4; k++) begin
         in_insns[k].dec_inst = $urandom;
         in_insns[k].rob_slot = 6'(next_slot + k);
      end
      in_enable    = en;
      in_count     = 2'(cnt);
      ext_enable   = xen;
      ext_consumed = 2'(xc);
      flush        = fl;
      if (fl) begin
         model.delete();
      end else begin
         n = xen ? xc + 1 : 0;
         if (n > model.size()) n = model.size();
         repeat (n) void'(model.pop_front());
         if (en && ready) begin
            for (int k = 0; k <= cnt; k++) model.push_back(in_insns[k]);
         end
      end
      if (en && ready && !fl) next_slot += cnt + 1;
      exp_q.push_back(snapshot(tag));
      @(posedge clock);
   endtask

   task automatic idle_inputs();
      @(negedge clock);
      in_enable = 0; ext_enable = 0; flush = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      for (int k = 0; k < 4; k++) in_insns[k] = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      chk("reset empty", 64'(empty), 64'd1);
      chk("reset in_ready", 64'(in_ready), 64'd1);
      chk("reset occupancy", 64'(occupancy), 64'd0);
      chk("reset ext_valid", 64'(ext_valid), 64'd0);
      for (int i = 0; i < 4; i++) chk($sformatf("reset insns[%0d]", i), 64'(insns[i]), 64'd0);

      // write 3, then pop 2 while writing 4
      step(1, 2, 0, 0, 0, "write3");
      step(1, 3, 1, 1, 0, "pop2_write4");
      // fill to 13, dropped write, pop 1, fill to 16
      step(1, 3, 0, 0, 0, "fill9");
      step(1, 3, 0, 0, 0, "fill13");
      step(1, 3, 0, 0, 0, "drop_write");
      step(0, 0, 1, 0, 0, "pop1");
      step(1, 3, 0, 0, 0, "fill16");
      // drain, flush to restart pointers at zero
      step(0, 0, 0, 0, 1, "flush_a");
      // walk both pointers to 14, then write 4 across the wrap
      for (int r = 0; r < 7; r++) begin
         step(1, 1, 0, 0, 0, "walk_w");
         step(0, 0, 1, 1, 0, "walk_r");
      end
      step(1, 3, 0, 0, 0, "wrap_write4");
      // occupancy 8, flush with push 4 and pop 4, then write 1
      step(1, 3, 0, 0, 0, "to8");
      step(1, 3, 1, 3, 1, "flush_pushpop");
      step(1, 0, 0, 0, 0, "after_flush");

      for (int c = 0; c < 400; c++) begin
         bit en, xen, fl;
         int cnt, xc, lim;
         en  = ($urandom_range(0, 3) != 0) && (model.size() <= DEPTH - 4);
         cnt = $urandom_range(0, 3);
         lim = (model.size() < 4) ? model.size() : 4;
         xen = (model.size() > 0) && ($urandom_range(0, 2) != 0);
         xc  = xen ? $urandom_range(0, lim - 1) : 0;
         fl  = ($urandom_range(0, 49) == 0);
         step(en, cnt, xen, xc, fl, "random");
      end

      idle_inputs();
      repeat (3) @(posedge clock);
      #2;
      chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

      // async reset in the middle of a write cycle
      @(negedge clock);
      in_enable = 1; in_count = 2'd3;
      #2;
      reset_n = 1'b0;
      #1;
      chk("midreset occupancy", 64'(occupancy), 64'd0);
      chk("midreset empty", 64'(empty), 64'd1);
      chk("midreset ext_valid", 64'(ext_valid), 64'd0);
      @(negedge clock);
      in_enable = 0;
      reset_n = 1'b1;
      model.delete();
      #1;
      chk("post_reset in_ready", 64'(in_ready), 64'd1);
      step(1, 0, 0, 0, 0, "post_reset_write");
      idle_inputs();
      repeat (2) @(posedge clock);
      #2;
      chk("final drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
